// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin ring arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int ARB_N        = 4;
   localparam int ARB_MAX_HOLD = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational circular priority pick: first set bit of req at or above the ptr position,
// wrapping past bit N-1, returned one-hot plus its binary index.
module rr_priority_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         ptr,
   output logic [N-1:0]         pick,
   output logic [$clog2(N)-1:0] pick_id
);
   localparam int IDW = $clog2(N);
   localparam int W2  = 2 * N;

   logic [W2-1:0] dbl;
   logic [W2-1:0] lowest;

   // Low half keeps only requests at/above ptr; high half is the unmasked wrap-around copy.
   assign dbl    = {req, req & ~(ptr - N'(1))};
   assign lowest = dbl & (~dbl + W2'(1));
   assign pick   = lowest[N-1:0] | lowest[W2-1:N];

   always_comb begin
      pick_id = '0;
      for (int i = 0; i < N; i++) begin
         if (pick[i]) pick_id = IDW'(i);
      end
   end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority ring, registered one-hot grant,
// bounded ownership (MAX_HOLD cycles) and a mandatory idle cycle between owners.
module rr_ring_arbiter
   import arb_pkg::*;
#(
   parameter int N        = ARB_N,
   parameter int MAX_HOLD = ARB_MAX_HOLD
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic [N-1:0]         ptr
);
   localparam int IDW = $clog2(N);
   localparam int CW  = $clog2(MAX_HOLD + 1);

   state_t         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [N-1:0]   gnt_nx, ptr_nx, pick;
   logic [IDW-1:0] gnt_id_nx, pick_id;
   logic           busy_nx;

   rr_priority_pick #(.N(N)) u_pick (
      .req     (req),
      .ptr     (ptr),
      .pick    (pick),
      .pick_id (pick_id)
   );

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      gnt_nx    = gnt;
      gnt_id_nx = gnt_id;
      busy_nx   = busy;
      ptr_nx    = ptr;
      case (state)
         IDLE: begin
            if (|req) begin
               gnt_nx    = pick;
               gnt_id_nx = pick_id;
               busy_nx   = 1'b1;
               cnt_nx    = '0;
               state_nx  = GRANT;
            end
         end
         GRANT: begin
            // A drop and a hold-limit hit on the same edge fold into one release.
            if (!req[gnt_id] || cnt == CW'(MAX_HOLD - 1)) begin
               gnt_nx    = '0;
               gnt_id_nx = '0;
               busy_nx   = 1'b0;
               ptr_nx    = {gnt[N-2:0], gnt[N-1]};
               state_nx  = IDLE;
            end else if (cnt != CW'(MAX_HOLD)) begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         gnt    <= '0;
         gnt_id <= '0;
         busy   <= 1'b0;
         ptr    <= N'(1);
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         gnt    <= gnt_nx;
         gnt_id <= gnt_id_nx;
         busy   <= busy_nx;
         ptr    <= ptr_nx;
      end
   end

endmodule

// File: doc/rr_ring_arbiter.md
# rr_ring_arbiter

Round-robin arbiter that shares one downstream resource among N requesters using a rotating one-hot priority ring. It issues a one-hot grant, holds it while the owner keeps requesting, bounds ownership with a hold limit, and rotates priority past the last owner on release. It sits between the requesting agents and the shared datapath, driving that datapath's select or enable.

## Interface
- N, 4, number of requesters (N >= 2)
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership (MAX_HOLD >= 1)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high
- req  input  N  request vector, bit i = requester i, level-sensitive
- gnt  output  N  registered one-hot grant, all-zero when idle
- gnt_id  output  $clog2(N)  binary index of the current owner, 0 when idle
- busy  output  1  high while any grant is asserted
- ptr  output  N  registered one-hot priority ring, the highest-priority position for the next pick

## Operation
- Reset, applied asynchronously: gnt=0, gnt_id=0, busy=0, ptr=1 (bit 0), state IDLE, hold counter=0.
- States:
  - IDLE: if req != 0, pick the first set bit of req scanning circularly upward from the ptr position (ptr bit inclusive). Load gnt, gnt_id and busy=1, clear the hold counter, and go to GRANT. If req == 0, stay in IDLE with ptr unchanged.
  - GRANT: the hold counter increments each cycle. Release occurs when req[gnt_id]==0, or when the counter equals MAX_HOLD-1 (ownership lasts exactly MAX_HOLD cycles). On release, in the same edge: gnt=0, gnt_id=0, busy=0, ptr = owner one-hot rotated left by 1 with wrap (bit N-1 goes to bit 0), and go to IDLE.
- Requests from non-owners during GRANT are ignored. They are evaluated in the next IDLE cycle.
- A hold-limit release and a request drop in the same cycle produce the same outcome: a single release.
- An owner released by the hold limit and still requesting competes normally. It wins again only if no other requester lies between the new ptr and itself.
- Invariants: gnt is zero or one-hot; ptr is always one-hot; busy == |gnt.
- Hold counter width is $clog2(MAX_HOLD+1). It saturates and never wraps in GRANT.

## Timing
- Grant latency is 1 cycle. req sampled at edge k gives gnt high after edge k.
- There is one mandatory idle cycle (gnt=0) between consecutive ownerships, so the resource never switches owners within a single edge.
- Release latency is 1 cycle. Owner req low before edge k gives gnt low after edge k.
- Reset asserted mid-grant drops gnt and busy immediately, without waiting for a clock edge, and restores ptr=1. Deassertion is synchronous to clk by system convention. The first grant can occur at the first edge after deassertion.
- All outputs are registered with no combinational path from req to gnt.

## Structure
- Shared package arb_pkg holds the state enum {IDLE, GRANT} and the default constants for N and MAX_HOLD.
- One sub-module, rr_priority_pick: combinational, takes req and ptr and returns a one-hot pick plus its binary index. It uses a double-width masked priority encoder.
- The top level holds the FSM, the hold counter, the ptr ring register and the output registers.

## Test plan
- Single requester, N=4: reset, then req=0100 for 3 cycles then 0000. Expect gnt=0100 and gnt_id=2 for 3 cycles, then gnt=0000 and ptr=1000.
- Full contention: req=1111 held, MAX_HOLD=2. Expect grants in the sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 2 cycles, separated by 1 idle cycle, and ptr advances each release.
- Wrap-around: ptr=1000 (set by a prior owner 0100), then req=0011. Expect gnt=0001, skipping the empty bit 3.
- Hold limit with persistent owner: MAX_HOLD=3, req=0010 only. Expect gnt=0010 for 3 cycles, 1 idle cycle, then gnt=0010 again for 3 cycles.
- Simultaneous drop and limit: MAX_HOLD=2, owner 0001 drops req in its 2nd grant cycle. Expect a single release, ptr=0010, and no double rotation.
- Reset mid-grant: assert reset asynchronously while gnt=0100. Expect gnt=0, busy=0 and ptr=0001 before the next clk edge. After deassertion with req=0100, expect gnt=0100 one cycle later.
